// File: rtl/fft_fmul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_fmul_pkg
// Description : Shared widths and operand/result types for the FFT float
//               multiplier sharing logic.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_fmul_pkg;

  localparam int MANT_W     = 10;
  localparam int EXP_W      = 5;
  localparam int RES_MANT_W = 15;

  typedef struct packed {
    logic [MANT_W-1:0] mant1;
    logic [EXP_W-1:0]  exp1;
    logic [MANT_W-1:0] mant2;
    logic [EXP_W-1:0]  exp2;
  } fmul_ops_t;

  typedef struct packed {
    logic [RES_MANT_W-1:0] mant;
    logic [EXP_W-1:0]      exp;
  } fmul_res_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fmul_share_arbiter_rr_grant.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant
// Description : One-hot grant generator; round-robin from i_ptr by default,
//               lowest-index fixed priority when FMUL_ARB_FIXED_PRI_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_grant
  import fft_fmul_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = idx_width(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_vld
);

`ifdef FMUL_ARB_FIXED_PRI_EN
  logic w_unused_ptr;
  assign w_unused_ptr = ^i_ptr;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_vld = 1'b0;
    // Scan downward so the lowest requesting index is the last one written.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (i_req[k]) begin
        o_vld = 1'b1;
        o_idx = IDX_W'(k);
      end
    end
    if (o_vld) o_gnt[o_idx] = 1'b1;
  end
`else
  localparam logic [IDX_W:0] c_nreq = (IDX_W+1)'(NREQ);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_cand;

  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_vld  = 1'b0;
    w_sum  = '0;
    w_cand = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
      if (w_sum >= c_nreq) w_sum = w_sum - c_nreq;
      w_cand = w_sum[IDX_W-1:0];
      if (!o_vld && i_req[w_cand]) begin
        o_vld = 1'b1;
        o_idx = w_cand;
      end
    end
    if (o_vld) o_gnt[o_idx] = 1'b1;
  end
`endif

endmodule
`default_nettype wire

// File: rtl/fmul_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fmul_share_arbiter
// Description : Shares one pipelined float multiplier among NREQ requesters;
//               a tag pipeline routes each product back as a one-cycle strobe.
//               Define FMUL_ARB_FIXED_PRI_EN for fixed (lowest index) priority.
// Revision    : 1.0 - initial release
// ============================================================================
module fmul_share_arbiter
  import fft_fmul_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int MULT_LAT = 2
) (
  input  logic                     clkExt,
  input  logic                     rst,
  input  logic [NREQ-1:0]          iReq,
  input  logic [NREQ*MANT_W-1:0]   iMant1,
  input  logic [NREQ*MANT_W-1:0]   iMant2,
  input  logic [NREQ*EXP_W-1:0]    iExp1,
  input  logic [NREQ*EXP_W-1:0]    iExp2,
  output logic [NREQ-1:0]          oAck,
  output logic [MANT_W-1:0]        oMulMant1,
  output logic [MANT_W-1:0]        oMulMant2,
  output logic [EXP_W-1:0]         oMulExp1,
  output logic [EXP_W-1:0]         oMulExp2,
  input  logic [RES_MANT_W-1:0]    iMulMantR,
  input  logic [EXP_W-1:0]         iMulExpR,
  output logic [NREQ-1:0]          oResValid,
  output logic [RES_MANT_W-1:0]    oResMant,
  output logic [EXP_W-1:0]         oResExp
);

  localparam int               IDX_W      = idx_width(NREQ);
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NREQ - 1);
  localparam logic [IDX_W-1:0] c_idx_one  = IDX_W'(1);
  localparam logic [NREQ-1:0]  c_slot_one = NREQ'(1);

  logic [NREQ-1:0]  w_gnt;
  logic [IDX_W-1:0] w_gidx;
  logic             w_gvld;
  logic             w_accept;
  fmul_ops_t        w_slot_ops [NREQ];

  logic [IDX_W-1:0] r_ptr;
  fmul_ops_t        r_ops;
  logic [MULT_LAT:0] r_tag_vld;
  logic [IDX_W-1:0] r_tag_idx [MULT_LAT+1];
  fmul_res_t        r_res;
  logic [NREQ-1:0]  r_res_vld;

  rr_grant #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_grant (
    .i_req (iReq),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gidx),
    .o_vld (w_gvld)
  );

  // Grant is suppressed during reset so no request can be consumed then.
  assign oAck     = (rst || !w_gvld) ? '0 : w_gnt;
  assign w_accept = |(iReq & oAck);

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign w_slot_ops[i] = {iMant1[i*MANT_W +: MANT_W], iExp1[i*EXP_W +: EXP_W],
                            iMant2[i*MANT_W +: MANT_W], iExp2[i*EXP_W +: EXP_W]};
  end

  always_ff @(posedge clkExt or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
      r_ops <= '0;
    end else if (w_accept) begin
      r_ptr <= (w_gidx == c_last_idx) ? '0 : w_gidx + c_idx_one;
      r_ops <= w_slot_ops[w_gidx];
    end
  end

  assign oMulMant1 = r_ops.mant1;
  assign oMulExp1  = r_ops.exp1;
  assign oMulMant2 = r_ops.mant2;
  assign oMulExp2  = r_ops.exp2;

  // Stage 0 lines up with operands entering the multiplier; the last stage
  // lines up with the product appearing at its output.
  always_ff @(posedge clkExt or posedge rst) begin
    if (rst) begin
      r_tag_vld <= '0;
      for (int k = 0; k <= MULT_LAT; k++) r_tag_idx[k] <= '0;
    end else begin
      r_tag_vld[0] <= w_accept;
      r_tag_idx[0] <= w_gidx;
      for (int k = 1; k <= MULT_LAT; k++) begin
        r_tag_vld[k] <= r_tag_vld[k-1];
        r_tag_idx[k] <= r_tag_idx[k-1];
      end
    end
  end

  always_ff @(posedge clkExt or posedge rst) begin
    if (rst) begin
      r_res     <= '0;
      r_res_vld <= '0;
    end else begin
      r_res_vld <= '0;
      if (r_tag_vld[MULT_LAT]) begin
        r_res_vld  <= c_slot_one << r_tag_idx[MULT_LAT];
        r_res.mant <= iMulMantR;
        r_res.exp  <= iMulExpR;
      end
    end
  end

  assign oResValid = r_res_vld;
  assign oResMant  = r_res.mant;
  assign oResExp   = r_res.exp;

endmodule
`default_nettype wire

// File: tb/tb_fmul_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fmul_share_arbiter
// Description : Directed self-checking bench for fmul_share_arbiter with a
//               two-stage multiplier model and an expected-result queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fmul_share_arbiter;

  localparam int NREQ     = 4;
  localparam int MULT_LAT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   iReq;
  logic [NREQ*10-1:0] iMant1, iMant2;
  logic [NREQ*5-1:0] iExp1, iExp2;
  logic [NREQ-1:0]   oAck;
  logic [9:0]        oMulMant1, oMulMant2;
  logic [4:0]        oMulExp1, oMulExp2;
  logic [14:0]       iMulMantR;
  logic [4:0]        iMulExpR;
  logic [NREQ-1:0]   oResValid;
  logic [14:0]       oResMant;
  logic [4:0]        oResExp;

  logic [9:0] r_m1 [NREQ];
  logic [9:0] r_m2 [NREQ];
  logic [4:0] r_e1 [NREQ];
  logic [4:0] r_e2 [NREQ];

  typedef struct {
    int          slot;
    logic [14:0] mant;
    logic [4:0]  exp;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic [19:0] r_mp1, r_mp2;

  fmul_share_arbiter #(.NREQ(NREQ), .MULT_LAT(MULT_LAT)) dut (
    .clkExt    (clk),
    .rst       (rst),
    .iReq      (iReq),
    .iMant1    (iMant1),
    .iMant2    (iMant2),
    .iExp1     (iExp1),
    .iExp2     (iExp2),
    .oAck      (oAck),
    .oMulMant1 (oMulMant1),
    .oMulMant2 (oMulMant2),
    .oMulExp1  (oMulExp1),
    .oMulExp2  (oMulExp2),
    .iMulMantR (iMulMantR),
    .iMulExpR  (iMulExpR),
    .oResValid (oResValid),
    .oResMant  (oResMant),
    .oResExp   (oResExp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    iMant1 = '0; iMant2 = '0; iExp1 = '0; iExp2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      iMant1[i*10 +: 10] = r_m1[i];
      iMant2[i*10 +: 10] = r_m2[i];
      iExp1[i*5 +: 5]    = r_e1[i];
      iExp2[i*5 +: 5]    = r_e2[i];
    end
  end

  // Product mantissa: signed 10x10 product scaled down by 32; exponent: sum.
  function automatic logic [19:0] fmul(input logic [9:0] a, input logic [4:0] ea,
                                       input logic [9:0] b, input logic [4:0] eb);
    int p;
    logic [4:0] e;
    p = $signed(a) * $signed(b);
    p = p >>> 5;
    e = ea + eb;
    return {p[14:0], e};
  endfunction

  always @(posedge clk) begin
    r_mp1 <= fmul(oMulMant1, oMulExp1, oMulMant2, oMulExp2);
    r_mp2 <= r_mp1;
  end
  assign iMulMantR = r_mp2[19:5];
  assign iMulExpR  = r_mp2[4:0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Drive one cycle of requests, check the grant and log any expected result.
  task automatic step(input logic [3:0] req, input logic [3:0] want_ack, input string tag);
    exp_t e;
    logic [19:0] p;
    iReq = req;
    @(negedge clk);
    check(tag, 32'(oAck), 32'(want_ack));
    for (int i = 0; i < NREQ; i++) begin
      if (want_ack[i]) begin
        p      = fmul(r_m1[i], r_e1[i], r_m2[i], r_e2[i]);
        e.slot = i;
        e.mant = p[19:5];
        e.exp  = p[4:0];
        e.due  = cyc + MULT_LAT + 2;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  always @(posedge rst) sb.delete();

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (oResValid != '0) begin
        if (sb.size() == 0) begin
          check("res_unexpected", 32'(oResValid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("res_slot", 32'(oResValid), 32'(1) << e.slot);
          check("res_mant", 32'(oResMant), 32'(e.mant));
          check("res_exp",  32'(oResExp),  32'(e.exp));
          check("res_cycle", cyc, e.due);
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check("res_missing", 32'(oResValid), 32'(1) << e.slot);
      end
    end
  end

  initial begin
    rst  = 1'b1;
    iReq = '0;
    for (int i = 0; i < NREQ; i++) begin
      r_m1[i] = '0; r_m2[i] = '0; r_e1[i] = '0; r_e2[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1 iReq = 4'hF;
    @(negedge clk);
    check("rst_ack",     32'(oAck), 32'd0);
    check("rst_resvld",  32'(oResValid), 32'd0);
    check("rst_resmant", 32'(oResMant), 32'd0);
    check("rst_resexp",  32'(oResExp), 32'd0);
    check("rst_mulm1",   32'(oMulMant1), 32'd0);
    check("rst_mule2",   32'(oMulExp2), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // all four slots contend: plain rotation 0,1,2,3
    for (int i = 0; i < NREQ; i++) begin
      r_m1[i] = 10'(64 * (i + 1)); r_e1[i] = 5'(i);
      r_m2[i] = 10'd128;           r_e2[i] = 5'd1;
    end
    step(4'b1111, 4'b0001, "t1_ack0");
    step(4'b1110, 4'b0010, "t1_ack1");
    step(4'b1100, 4'b0100, "t1_ack2");
    step(4'b1000, 4'b1000, "t1_ack3");
    repeat (6) step(4'b0000, 4'b0000, "t1_idle");

    // slots 0 and 2 held continuously
    r_m1[0] = 10'd3;    r_e1[0] = 5'd2;  r_m2[0] = 10'd100;  r_e2[0] = 5'd3;
    r_m1[2] = -10'sd5;  r_e1[2] = -5'sd4; r_m2[2] = 10'd200; r_e2[2] = 5'd1;
`ifdef FMUL_ARB_FIXED_PRI_EN
    for (int k = 0; k < 4; k++) step(4'b0101, 4'b0001, "t2_ack");
`else
    for (int k = 0; k < 4; k++) step(4'b0101, (k % 2 == 0) ? 4'b0001 : 4'b0100, "t2_ack");
`endif
    repeat (6) step(4'b0000, 4'b0000, "t2_idle");

    // slot 1 alone, new operands every cycle
    for (int k = 0; k < 5; k++) begin
      r_m1[1] = 10'(10 * (k + 1)); r_e1[1] = 5'(k);
      r_m2[1] = -10'sd64;          r_e2[1] = 5'd2;
      step(4'b0010, 4'b0010, "t3_ack");
    end
    repeat (6) step(4'b0000, 4'b0000, "t3_idle");

    // two accepts, then reset while both are in flight
`ifdef FMUL_ARB_FIXED_PRI_EN
    step(4'b0110, 4'b0010, "t4_ack_a");
    step(4'b0100, 4'b0100, "t4_ack_b");
`else
    step(4'b0110, 4'b0100, "t4_ack_a");
    step(4'b0010, 4'b0010, "t4_ack_b");
`endif
    rst  = 1'b1;
    iReq = 4'b0000;
    @(negedge clk);
    check("t4_rst_ack", 32'(oAck), 32'd0);
    check("t4_rst_vld", 32'(oResValid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    r_m1[0] = 10'd7; r_e1[0] = 5'd1; r_m2[0] = 10'd96; r_e2[0] = 5'd1;
    r_m1[3] = 10'd11; r_e1[3] = 5'd3; r_m2[3] = -10'sd40; r_e2[3] = 5'd2;
    step(4'b1001, 4'b0001, "t4_ptr0");
    repeat (6) step(4'b0000, 4'b0000, "t4_idle");

    // slot 3 withdraws while slot 0 holds the grant
    step(4'b1000, 4'b1000, "t5_ack3a");
    step(4'b1001, 4'b0001, "t5_ack0");
    step(4'b0000, 4'b0000, "t5_drop3");
    r_m1[3] = -10'sd100; r_e1[3] = 5'd6;
    step(4'b1000, 4'b1000, "t5_ack3b");
    repeat (6) step(4'b0000, 4'b0000, "t5_idle");

    // slots 0 and 1 held
`ifdef FMUL_ARB_FIXED_PRI_EN
    for (int k = 0; k < 4; k++) step(4'b0011, 4'b0001, "t6_ack");
`else
    for (int k = 0; k < 4; k++) step(4'b0011, (k % 2 == 0) ? 4'b0001 : 4'b0010, "t6_ack");
`endif
    repeat (8) step(4'b0000, 4'b0000, "t6_idle");

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
